// File: rtl/regfile_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port register file.
// Each granted request runs a short write or read transaction; all outputs are registered.
module regfile_arbiter #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        gnt,
    output logic [1:0]        ack,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [ADDR_W-1:0] rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Command latched at selection; isolates the transaction from later input changes.
    logic              winner_q, winner_d;
    logic              cmd_we_q, cmd_we_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
    logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;

    // Index of the requester served last; reset value 1 lets requester 0 win first.
    logic last_q, last_d;

    logic [1:0]        gnt_d;
    logic [1:0]        ack_d;
    logic [DATA_W-1:0] rdata_d;
    logic              busy_d;
    logic              rf_we_d;
    logic [ADDR_W-1:0] rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_d;
    logic [ADDR_W-1:0] rf_raddr_d;

    // Selection helpers for the IDLE decision.
    logic              sel_win;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // Contention goes to the requester not served last; a lone request always wins.
    always_comb begin
        sel_win   = req[0] ? (req[1] & ~last_q) : 1'b1;
        sel_we    = sel_win ? we[1] : we[0];
        sel_addr  = sel_win ? addr1 : addr0;
        sel_wdata = sel_win ? wdata1 : wdata0;
    end

    // Next-state logic; output values are computed for the state being entered.
    always_comb begin
        state_d     = state_q;
        winner_d    = winner_q;
        cmd_we_d    = cmd_we_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        last_d      = last_q;
        gnt_d       = 2'b00;
        ack_d       = 2'b00;
        rdata_d     = rdata;
        busy_d      = 1'b0;
        rf_we_d     = 1'b0;
        rf_waddr_d  = '0;
        rf_wdata_d  = '0;
        rf_raddr_d  = '0;

        unique case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    winner_d    = sel_win;
                    cmd_we_d    = sel_we;
                    cmd_addr_d  = sel_addr;
                    cmd_wdata_d = sel_wdata;
                    gnt_d       = {sel_win, ~sel_win};
                    busy_d      = 1'b1;
                    if (sel_we) begin
                        state_d    = WRITE;
                        ack_d      = {sel_win, ~sel_win};
                        rf_we_d    = (sel_addr != ADDR_W'(0));
                        rf_waddr_d = sel_addr;
                        rf_wdata_d = sel_wdata;
                    end else begin
                        state_d    = READ;
                        rf_raddr_d = sel_addr;
                    end
                end
            end
            WRITE: begin
                state_d = IDLE;
                last_d  = winner_q;
            end
            READ: begin
                state_d    = RESP;
                gnt_d      = {winner_q, ~winner_q};
                ack_d      = {winner_q, ~winner_q};
                busy_d     = 1'b1;
                rf_raddr_d = cmd_addr_q;
                rdata_d    = (cmd_addr_q == ADDR_W'(0)) ? DATA_W'(0) : rf_rdata;
            end
            RESP: begin
                state_d = IDLE;
                last_d  = winner_q;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, latched command and round-robin pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            winner_q    <= 1'b0;
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            last_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            winner_q    <= winner_d;
            cmd_we_q    <= cmd_we_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            last_q      <= last_d;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt      <= 2'b00;
            ack      <= 2'b00;
            rdata    <= '0;
            busy     <= 1'b0;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            rf_raddr <= '0;
        end else begin
            gnt      <= gnt_d;
            ack      <= ack_d;
            rdata    <= rdata_d;
            busy     <= busy_d;
            rf_we    <= rf_we_d;
            rf_waddr <= rf_waddr_d;
            rf_wdata <= rf_wdata_d;
            rf_raddr <= rf_raddr_d;
        end
    end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter with a behavioural register file attached.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_regfile_arbiter;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 4;

    logic              clk;
    logic              rst;
    logic [1:0]        req;
    logic [1:0]        we;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic [1:0]        gnt;
    logic [1:0]        ack;
    logic [DATA_W-1:0] rdata;
    logic              busy;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [ADDR_W-1:0] rf_raddr;
    logic [DATA_W-1:0] rf_rdata;

    int n_checks;
    int n_fail;

    logic [DATA_W-1:0] mem [16];

    regfile_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .we       (we),
        .addr0    (addr0),
        .addr1    (addr1),
        .wdata0   (wdata0),
        .wdata1   (wdata1),
        .gnt      (gnt),
        .ack      (ack),
        .rdata    (rdata),
        .busy     (busy),
        .rf_we    (rf_we),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata),
        .rf_raddr (rf_raddr),
        .rf_rdata (rf_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: synchronous write, combinational read mux.
    always @(posedge clk) begin
        if (rf_we) mem[rf_waddr] <= rf_wdata;
    end
    assign rf_rdata = mem[rf_raddr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        check({tag, " gnt"}, 32'(gnt), 32'h0);
        check({tag, " ack"}, 32'(ack), 32'h0);
        check({tag, " busy"}, 32'(busy), 32'h0);
        check({tag, " rf_we"}, 32'(rf_we), 32'h0);
        check({tag, " rf_raddr"}, 32'(rf_raddr), 32'h0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        mem[0] = 8'h3C;
        mem[7] = 8'h77;
        mem[9] = 8'h99;
        req = 2'b00; we = 2'b00;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        rst = 1'b0;

        // Reset state
        step();
        check_idle("reset");
        check("reset rdata", 32'(rdata), 32'h0);
        check("reset rf_waddr", 32'(rf_waddr), 32'h0);
        check("reset rf_wdata", 32'(rf_wdata), 32'h0);
        rst = 1'b1;

        // Single write: requester 0 writes 0xA5 to register 5
        req = 2'b01; we = 2'b01; addr0 = 4'd5; wdata0 = 8'hA5;
        step();
        check("wr gnt", 32'(gnt), 32'h1);
        check("wr ack", 32'(ack), 32'h1);
        check("wr rf_we", 32'(rf_we), 32'h1);
        check("wr rf_waddr", 32'(rf_waddr), 32'h5);
        check("wr rf_wdata", 32'(rf_wdata), 32'hA5);
        check("wr busy", 32'(busy), 32'h1);
        req = 2'b00;
        step();
        check_idle("wr done");
        check("wr done waddr", 32'(rf_waddr), 32'h0);

        // Single read: requester 1 reads register 5
        req = 2'b10; we = 2'b00; addr1 = 4'd5;
        step();
        check("rd gnt", 32'(gnt), 32'h2);
        check("rd rf_raddr", 32'(rf_raddr), 32'h5);
        check("rd ack early", 32'(ack), 32'h0);
        req = 2'b00;
        step();
        check("rd ack", 32'(ack), 32'h2);
        check("rd rdata", 32'(rdata), 32'hA5);
        check("rd raddr held", 32'(rf_raddr), 32'h5);
        step();
        check_idle("rd done");
        check("rd rdata hold", 32'(rdata), 32'hA5);

        // Contention: both requesters write continuously; grants must alternate
        req = 2'b11; we = 2'b11;
        addr0 = 4'd1; wdata0 = 8'h11; addr1 = 4'd2; wdata1 = 8'h22;
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("rr gnt %0d", k), 32'(gnt), (k % 2 == 0) ? 32'h1 : 32'h2);
            check($sformatf("rr ack %0d", k), 32'(ack), (k % 2 == 0) ? 32'h1 : 32'h2);
            check($sformatf("rr waddr %0d", k), 32'(rf_waddr), (k % 2 == 0) ? 32'h1 : 32'h2);
            step();
            check($sformatf("rr gap %0d", k), 32'(gnt), 32'h0);
        end
        req = 2'b00;
        check("rr mem1", 32'(mem[1]), 32'h11);
        check("rr mem2", 32'(mem[2]), 32'h22);

        // Write to register 0 is acked but never reaches the register file
        req = 2'b01; we = 2'b01; addr0 = 4'd0; wdata0 = 8'hFF;
        step();
        check("z wr ack", 32'(ack), 32'h1);
        check("z wr rf_we", 32'(rf_we), 32'h0);
        req = 2'b00;
        step();
        check("z mem0", 32'(mem[0]), 32'h3C);

        // Read of register 0 returns zero regardless of the mux output
        req = 2'b01; we = 2'b00; addr0 = 4'd0;
        step();
        req = 2'b00;
        step();
        check("z rd ack", 32'(ack), 32'h1);
        check("z rd rdata", 32'(rdata), 32'h0);
        step();

        // Inputs change after selection: original address still used
        req = 2'b01; we = 2'b00; addr0 = 4'd7;
        step();
        check("hold raddr", 32'(rf_raddr), 32'h7);
        addr0 = 4'd9; req = 2'b00;
        step();
        check("hold ack", 32'(ack), 32'h1);
        check("hold raddr2", 32'(rf_raddr), 32'h7);
        check("hold rdata", 32'(rdata), 32'h77);
        step();

        // Reset during READ aborts asynchronously
        req = 2'b01; we = 2'b00; addr0 = 4'd9;
        step();
        check("abort pre gnt", 32'(gnt), 32'h1);
        #2 rst = 1'b0;
        #1;
        check_idle("abort async");
        check("abort rdata", 32'(rdata), 32'h0);
        step();
        check("abort no ack", 32'(ack), 32'h0);
        check("abort busy", 32'(busy), 32'h0);
        rst = 1'b1;

        // After release the pointer is back at its reset value: requester 0 wins
        req = 2'b11; we = 2'b00; addr0 = 4'd9; addr1 = 4'd7;
        step();
        check("post gnt", 32'(gnt), 32'h1);
        check("post raddr", 32'(rf_raddr), 32'h9);
        req = 2'b00;
        step();
        check("post ack", 32'(ack), 32'h1);
        check("post rdata", 32'(rdata), 32'h99);
        step();
        check_idle("post done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
